// File: rtl/bus_ram_loader_pkg.sv
// Shared definitions for the CPU bus RAM with clear engine and program loader.
//
// Contents:
//   state_t : FSM encoding shared by the top level and anyone probing it
//             ST_CLEAR - clear engine owns the array
//             ST_IDLE  - CPU port owns the array
//             ST_LOAD  - streaming loader owns the array
package bus_ram_loader_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_ram_sp.sv
// Single-port synchronous RAM: one write port, registered read address,
// read-returns-new-data.
//
// Ports:
//   clk      in   1   clock, writes and address register update on posedge
//   reset    in   1   synchronous active-high, clears only the address register
//   we       in   1   write enable
//   waddr    in   AW  write address
//   wdata    in   DW  write data
//   addr_en  in   1   1: capture raddr into the address register this edge
//   raddr    in   AW  read address
//   rdata    out  DW  mem[addr_reg], combinational from the registered address
module sync_ram_sp #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          addr_en,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [AW-1:0] addr_reg;

    // Storage is deliberately not reset; only the clear engine rewrites it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Holding the address keeps rdata stable while the CPU is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg <= '0;
        end else if (addr_en) begin
            addr_reg <= raddr;
        end
    end

    // Reading after the edge sees both the new address and any data written
    // on that same edge, which gives read-new-data behaviour.
    assign rdata = mem[addr_reg];

endmodule

// File: rtl/bus_ram_loader.sv
// CPU bus RAM with power-on clear engine and streaming program-load port.
// Clear and load take exclusive ownership of the array and stall the CPU
// through cpu_rdy (6502 RDY).
//
// Ports:
//   clk       in   1     single clock
//   reset     in   1     synchronous active-high
//   cpu_ab    in   AW    CPU address bus
//   cpu_do    in   DW    CPU write data
//   cpu_we    in   1     CPU write enable
//   cpu_di    out  DW    read data to CPU = mem[addr_reg]
//   cpu_rdy   out  1     1 = CPU port serviced
//   ld_start  in   1     pulse: begin load at ld_addr
//   ld_addr   in   AW    load start address
//   ld_valid  in   1     load beat valid
//   ld_data   in   DW    load beat data
//   ld_last   in   1     final beat of this load
//   ld_ready  out  1     loader accepts a beat this cycle
//   ld_count  out  AW+1  beats written by current/most recent load
//   busy      out  1     clear or load in progress
module bus_ram_loader
    import bus_ram_loader_pkg::*;
#(
    parameter int            AW             = 16,
    parameter int            DW             = 8,
    parameter bit            CLEAR_ON_RESET = 1'b1,
    parameter logic [DW-1:0] CLEAR_VALUE    = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_ab,
    input  logic [DW-1:0] cpu_do,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_di,
    output logic          cpu_rdy,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_addr,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic [AW:0]   ld_count,
    output logic          busy
);

    localparam logic [AW:0] COUNT_MAX = {1'b1, {AW{1'b0}}};

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] clr_ptr;
    logic [AW-1:0] ld_ptr;
    logic          beat_ok;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    assign cpu_rdy  = (state == ST_IDLE);
    assign ld_ready = (state == ST_LOAD);
    assign busy     = (state != ST_IDLE);
    assign beat_ok  = ld_ready && ld_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_CLEAR: if (clr_ptr == '1)          next_state = ST_IDLE;
            ST_IDLE:  if (ld_start)               next_state = ST_LOAD;
            ST_LOAD:  if (beat_ok && ld_last)     next_state = ST_IDLE;
            default:                              next_state = ST_IDLE;
        endcase
    end

    // Pointers wrap naturally at 2**AW; the beat counter saturates so a
    // full-array load still reports 2**AW rather than rolling to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_ptr  <= '0;
            ld_ptr   <= '0;
            ld_count <= '0;
        end else begin
            case (state)
                ST_CLEAR: clr_ptr <= clr_ptr + 1'b1;
                ST_IDLE: begin
                    if (ld_start) begin
                        ld_ptr   <= ld_addr;
                        ld_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (beat_ok) begin
                        ld_ptr <= ld_ptr + 1'b1;
                        if (ld_count != COUNT_MAX) begin
                            ld_count <= ld_count + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The state alone picks the owner of the single write port, so two
    // writers can never collide on the same edge.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cpu_ab;
        mem_wdata = cpu_do;
        case (state)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_wdata = CLEAR_VALUE;
            end
            ST_IDLE: mem_we = cpu_we;
            ST_LOAD: begin
                mem_we    = beat_ok;
                mem_waddr = ld_ptr;
                mem_wdata = ld_data;
            end
            default: ;
        endcase
    end

    sync_ram_sp #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .addr_en (cpu_rdy),
        .raddr   (cpu_ab),
        .rdata   (cpu_di)
    );

endmodule

// File: tb/tb_bus_ram_loader.sv
// Directed bench for bus_ram_loader. A small AW=8 instance exercises the
// clear engine and reset-during-load; a full AW=16 instance without clear
// exercises the CPU port, loading, pointer wrap and port collisions.
module tb_bus_ram_loader;

    logic clk;
    logic reset8;
    logic reset16;

    int checks;
    int errors;

    // AW=8 instance, clears to 'hA5
    logic [7:0]  ab8;
    logic [7:0]  do8;
    logic        we8;
    logic [7:0]  di8;
    logic        rdy8;
    logic        start8;
    logic [7:0]  laddr8;
    logic        valid8;
    logic [7:0]  ldata8;
    logic        last8;
    logic        ready8;
    logic [8:0]  count8;
    logic        busy8;

    // AW=16 instance, no clear
    logic [15:0] ab16;
    logic [7:0]  do16;
    logic        we16;
    logic [7:0]  di16;
    logic        rdy16;
    logic        start16;
    logic [15:0] laddr16;
    logic        valid16;
    logic [7:0]  ldata16;
    logic        last16;
    logic        ready16;
    logic [16:0] count16;
    logic        busy16;

    bus_ram_loader #(
        .AW             (8),
        .DW             (8),
        .CLEAR_ON_RESET (1'b1),
        .CLEAR_VALUE    (8'hA5)
    ) dut8 (
        .clk      (clk),
        .reset    (reset8),
        .cpu_ab   (ab8),
        .cpu_do   (do8),
        .cpu_we   (we8),
        .cpu_di   (di8),
        .cpu_rdy  (rdy8),
        .ld_start (start8),
        .ld_addr  (laddr8),
        .ld_valid (valid8),
        .ld_data  (ldata8),
        .ld_last  (last8),
        .ld_ready (ready8),
        .ld_count (count8),
        .busy     (busy8)
    );

    bus_ram_loader #(
        .AW             (16),
        .DW             (8),
        .CLEAR_ON_RESET (1'b0),
        .CLEAR_VALUE    (8'h00)
    ) dut16 (
        .clk      (clk),
        .reset    (reset16),
        .cpu_ab   (ab16),
        .cpu_do   (do16),
        .cpu_we   (we16),
        .cpu_di   (di16),
        .cpu_rdy  (rdy16),
        .ld_start (start16),
        .ld_addr  (laddr16),
        .ld_valid (valid16),
        .ld_data  (ldata16),
        .ld_last  (last16),
        .ld_ready (ready16),
        .ld_count (count16),
        .busy     (busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle on the AW=16 instance; called and returns at negedge.
    task automatic applyStimulus(input logic [15:0] ab, input logic [7:0] dout, input logic we,
                                 input logic start, input logic [15:0] laddr,
                                 input logic valid, input logic [7:0] ldata, input logic last);
        ab16    = ab;
        do16    = dout;
        we16    = we;
        start16 = start;
        laddr16 = laddr;
        valid16 = valid;
        ldata16 = ldata;
        last16  = last;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read16(input logic [15:0] addr, input logic [7:0] exp, input string tag);
        applyStimulus(addr, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0);
        checkOutput(tag, {24'h0, di16}, {24'h0, exp});
    endtask

    task automatic read8(input logic [7:0] addr, input logic [7:0] exp, input string tag);
        ab8 = addr;
        we8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput(tag, {24'h0, di8}, {24'h0, exp});
    endtask

    // Counts edges until the AW=8 instance reports cpu_rdy; bounded.
    task automatic waitClear8(output int cycles, input bit poke);
        cycles = 0;
        if (poke) begin
            ab8 = 8'h10;
            do8 = 8'h3C;
            we8 = 1'b1;
        end
        while (!rdy8 && cycles < 1000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 100) we8 = 1'b0;
        end
        we8 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        bit mismatch_any;
        checks  = 0;
        errors  = 0;
        reset8  = 1'b1;
        reset16 = 1'b1;
        ab8 = '0; do8 = '0; we8 = 1'b0; start8 = 1'b0; laddr8 = '0;
        valid8 = 1'b0; ldata8 = '0; last8 = 1'b0;
        ab16 = '0; do16 = '0; we16 = 1'b0; start16 = 1'b0; laddr16 = '0;
        valid16 = 1'b0; ldata16 = '0; last16 = 1'b0;

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst8_busy",      {31'h0, busy8},   32'd1);
        checkOutput("rst8_rdy",       {31'h0, rdy8},    32'd0);
        checkOutput("rst8_ld_ready",  {31'h0, ready8},  32'd0);
        checkOutput("rst8_ld_count",  {23'h0, count8},  32'd0);
        checkOutput("rst16_busy",     {31'h0, busy16},  32'd0);
        checkOutput("rst16_rdy",      {31'h0, rdy16},   32'd1);
        checkOutput("rst16_ld_ready", {31'h0, ready16}, 32'd0);
        checkOutput("rst16_ld_count", {15'h0, count16}, 32'd0);

        $display("[TB] clear engine");
        reset8 = 1'b0;
        waitClear8(cyc, 1'b1);
        checkOutput("clear_cycles", cyc, 32'd256);
        read8(8'h10, 8'hA5, "clear_cpu_we_ignored");
        mismatch_any = 1'b0;
        for (int a = 0; a < 256; a++) begin
            ab8 = 8'(a);
            @(posedge clk);
            @(negedge clk);
            if (di8 !== 8'hA5) mismatch_any = 1'b1;
        end
        checkOutput("clear_all_a5", {31'h0, mismatch_any}, 32'd0);

        $display("[TB] reset during load");
        start8 = 1'b1; laddr8 = 8'h40;
        @(posedge clk); @(negedge clk);
        start8 = 1'b0;
        checkOutput("ml_ready", {31'h0, ready8}, 32'd1);
        valid8 = 1'b1; ldata8 = 8'h11;
        @(posedge clk); @(negedge clk);
        ldata8 = 8'h22;
        @(posedge clk); @(negedge clk);
        checkOutput("ml_count2", {23'h0, count8}, 32'd2);
        reset8 = 1'b1; ldata8 = 8'h33;
        @(posedge clk); @(negedge clk);
        checkOutput("ml_rst_count", {23'h0, count8}, 32'd0);
        checkOutput("ml_rst_ready", {31'h0, ready8}, 32'd0);
        checkOutput("ml_rst_busy",  {31'h0, busy8},  32'd1);
        checkOutput("ml_rst_rdy",   {31'h0, rdy8},   32'd0);
        reset8 = 1'b0; valid8 = 1'b0;
        waitClear8(cyc, 1'b0);
        checkOutput("ml_clear_cycles", cyc, 32'd256);
        read8(8'h40, 8'hA5, "ml_recleared_40");
        read8(8'h41, 8'hA5, "ml_recleared_41");

        $display("[TB] cpu read/write");
        reset16 = 1'b0;
        applyStimulus(16'h1300, 8'h47, 1'b1, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0);
        checkOutput("rw_new_data", {24'h0, di16}, 32'h47);
        read16(16'h1300, 8'h47, "rw_read_1300");
        applyStimulus(16'h1301, 8'h99, 1'b1, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0);
        read16(16'h1300, 8'h47, "rw_reread_1300");
        read16(16'h1301, 8'h99, "rw_read_1301");

        $display("[TB] load with gap");
        applyStimulus(16'h0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0);
        checkOutput("ld_busy",    {31'h0, busy16},  32'd1);
        checkOutput("ld_ready",   {31'h0, ready16}, 32'd1);
        checkOutput("ld_rdy_low", {31'h0, rdy16},   32'd0);
        checkOutput("ld_count0",  {15'h0, count16}, 32'd0);
        applyStimulus(16'h0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1, 8'h38, 1'b0);
        applyStimulus(16'h0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1, 8'hA9, 1'b0);
        applyStimulus(16'h0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0, 8'hFF, 1'b0);
        checkOutput("ld_gap_count", {15'h0, count16}, 32'd2);
        checkOutput("ld_gap_ready", {31'h0, ready16}, 32'd1);
        applyStimulus(16'h0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1, 8'h23, 1'b1);
        checkOutput("ld_done_rdy",   {31'h0, rdy16},   32'd1);
        checkOutput("ld_done_count", {15'h0, count16}, 32'd3);
        read16(16'h0000, 8'h38, "ld_mem0");
        read16(16'h0001, 8'hA9, "ld_mem1");
        read16(16'h0002, 8'h23, "ld_mem2");
        checkOutput("ld_count_held", {15'h0, count16}, 32'd3);

        $display("[TB] load wrap");
        applyStimulus(16'h0, 8'h00, 1'b0, 1'b1, 16'hFFFE, 1'b0, 8'h00, 1'b0);
        applyStimulus(16'h0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1, 8'h01, 1'b0);
        applyStimulus(16'h0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1, 8'h02, 1'b0);
        applyStimulus(16'h0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1, 8'h03, 1'b0);
        applyStimulus(16'h0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1, 8'h04, 1'b1);
        checkOutput("wrap_count", {15'h0, count16}, 32'd4);
        read16(16'hFFFE, 8'h01, "wrap_fffe");
        read16(16'hFFFF, 8'h02, "wrap_ffff");
        read16(16'h0000, 8'h03, "wrap_0000");
        read16(16'h0001, 8'h04, "wrap_0001");
        applyStimulus(16'h0005, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1, 8'hFF, 1'b1);
        read16(16'h0002, 8'h23, "idle_valid_ignored");
        checkOutput("idle_count_held", {15'h0, count16}, 32'd4);

        $display("[TB] collision");
        applyStimulus(16'h0021, 8'h11, 1'b1, 1'b0, 16'h0, 1'b0, 8'h00, 1'b0);
        applyStimulus(16'h0020, 8'h55, 1'b1, 1'b1, 16'h0100, 1'b0, 8'h00, 1'b0);
        checkOutput("col_busy",     {31'h0, busy16}, 32'd1);
        checkOutput("col_new_data", {24'h0, di16},   32'h55);
        applyStimulus(16'h0021, 8'h77, 1'b1, 1'b1, 16'h0300, 1'b0, 8'h00, 1'b0);
        checkOutput("col_di_stable", {24'h0, di16},    32'h55);
        checkOutput("col_count0",    {15'h0, count16}, 32'd0);
        applyStimulus(16'h0021, 8'h77, 1'b1, 1'b0, 16'h0, 1'b1, 8'hEE, 1'b1);
        checkOutput("col_count1", {15'h0, count16}, 32'd1);
        checkOutput("col_rdy",    {31'h0, rdy16},   32'd1);
        read16(16'h0021, 8'h11, "col_21_unchanged");
        read16(16'h0020, 8'h55, "col_20_written");
        read16(16'h0100, 8'hEE, "col_load_addr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
